// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the iterative cipher core and its S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  // out byte index -> in byte index for ShiftRows
  localparam int SR_MAP [16] = '{
    0, 5, 10, 15,
    4, 9, 14, 3,
    8, 13, 2, 7,
    12, 1, 6, 11
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = c;
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_cipher_iter_sbox.sv
// Combinational AES forward S-box.
// Table is row-major, entry 0x00 in the top byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[11'd2047 - {a, 3'b000} -: 8];

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/256 encryptor: one round per clock,
// on-the-fly key schedule, valid/ready on both sides.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        datain,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        dataout,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_cipher_iter: KEY_BITS must be 128 or 256");
  end

  state_e                state_q, state_d;
  logic [3:0]            rnd_q, rnd_d;
  logic [127:0]          st_q, st_d;
  logic [127:0]          dout_q, dout_d;
  logic [KEY_BITS-1:0]   win_q, win_d, win_nxt;

  logic [127:0] sb, sr, mc, rk, rnd_out;
  logic [31:0]  last, sw_in, sw_out, temp;
  logic [31:0]  n0, n1, n2, n3;
  logic         rot;
  logic [3:0]   rc_idx;

  for (genvar b = 0; b < 16; b++) begin : g_sub
    aes_sbox u_sbox (
      .a(st_q[127-8*b -: 8]),
      .y(sb[127-8*b -: 8])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_subw
    aes_sbox u_sbox (
      .a(sw_in[31-8*j -: 8]),
      .y(sw_out[31-8*j -: 8])
    );
  end

  always_comb begin
    for (int b = 0; b < 16; b++) begin
      sr[127-8*b -: 8] = sb[127-8*SR_MAP[b] -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end
  end

  // AES-256 alternates RotWord+Rcon (odd rounds) and plain SubWord
  always_comb begin
    last   = win_q[31:0];
    rot    = (NK == 4) || rnd_q[0];
    rc_idx = (NK == 4) ? rnd_q : 4'((rnd_q + 4'd1) >> 1);
    sw_in  = rot ? {last[23:0], last[31:24]} : last;
    temp   = rot ? (sw_out ^ {rcon(rc_idx), 24'h0}) : sw_out;
    n0     = win_q[KEY_BITS-1  -: 32] ^ temp;
    n1     = win_q[KEY_BITS-33 -: 32] ^ n0;
    n2     = win_q[KEY_BITS-65 -: 32] ^ n1;
    n3     = win_q[KEY_BITS-97 -: 32] ^ n2;
  end

  if (NK == 4) begin : g_ks128
    assign rk      = {n0, n1, n2, n3};
    assign win_nxt = {n0, n1, n2, n3};
  end else begin : g_ks256
    assign rk      = win_q[127:0];
    assign win_nxt = {win_q[127:0], n0, n1, n2, n3};
  end

  assign rnd_out = ((rnd_q == 4'(NR)) ? sr : mc) ^ rk;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    win_d   = win_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ROUND;
          st_d    = datain ^ key[KEY_BITS-1 -: 128];
          win_d   = key;
          rnd_d   = 4'd1;
        end
      end
      ROUND: begin
        st_d  = rnd_out;
        win_d = win_nxt;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NR)) begin
          state_d = DONE;
          dout_d  = rnd_out;
          rnd_d   = 4'd0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      st_q    <= '0;
      win_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      win_q   <= win_d;
      dout_q  <= dout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dataout   = dout_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter, AES-128 and AES-256
// instances side by side, FIPS-197 vectors.
module tb_aes_cipher_iter;

  logic clk, rst;

  logic         iv1, ir1, ov1, or1, bz1;
  logic [127:0] d1, q1;
  logic [127:0] k1;

  logic         iv2, ir2, ov2, or2, bz2;
  logic [127:0] d2, q2;
  logic [255:0] k2;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K_C  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_cipher_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .datain(d1), .key(k1),
    .out_valid(ov1), .out_ready(or1),
    .dataout(q1), .busy(bz1)
  );

  aes_cipher_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2),
    .datain(d2), .key(k2),
    .out_valid(ov2), .out_ready(or2),
    .dataout(q2), .busy(bz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input bit w, input logic [127:0] pt,
                       input logic [255:0] k);
    int n = 0;
    while (!(w ? ir2 : ir1) && n < 50) begin
      step(1);
      n++;
    end
    check("in_ready_wait", {127'b0, (w ? ir2 : ir1)}, 128'd1);
    if (w) begin
      iv2 = 1'b1; d2 = pt; k2 = k;
    end else begin
      iv1 = 1'b1; d1 = pt; k1 = k[255:128];
    end
    step(1);
    iv1 = 1'b0;
    iv2 = 1'b0;
  endtask

  task automatic wait_out(input bit w, output logic [127:0] ct,
                          output int lat);
    lat = 0;
    while (!(w ? ov2 : ov1) && lat < 60) begin
      step(1);
      lat++;
    end
    check("out_valid_wait", {127'b0, (w ? ov2 : ov1)}, 128'd1);
    ct = w ? q2 : q1;
  endtask

  task automatic pop(input bit w);
    if (w) or2 = 1'b1;
    else   or1 = 1'b1;
    step(1);
    or1 = 1'b0;
    or2 = 1'b0;
  endtask

  initial begin
    logic [127:0] ct;
    int lat, chg, outs;

    rst = 1'b1;
    iv1 = 0; or1 = 0; d1 = '0; k1 = '0;
    iv2 = 0; or2 = 0; d2 = '0; k2 = '0;
    step(2);
    check("rst_in_ready128", {127'b0, ir1}, 128'd1);
    check("rst_out_valid128", {127'b0, ov1}, 128'd0);
    check("rst_busy128", {127'b0, bz1}, 128'd0);
    check("rst_dataout128", q1, 128'd0);
    check("rst_in_ready256", {127'b0, ir2}, 128'd1);
    check("rst_dataout256", q2, 128'd0);
    rst = 1'b0;
    step(1);

    // 1: FIPS-197 C.1, latency 10
    start(0, P_A, {K_A, 128'h0});
    check("busy_round", {127'b0, bz1}, 128'd1);
    wait_out(0, ct, lat);
    check("v1_ct", ct, C_A);
    check("v1_lat", 128'(lat), 128'd10);
    pop(0);
    check("v1_idle", {127'b0, ir1}, 128'd1);
    check("v1_hold", q1, C_A);

    // 2: FIPS-197 appendix B
    start(0, P_B, {K_B, 128'h0});
    wait_out(0, ct, lat);
    check("v2_ct", ct, C_B);
    pop(0);

    // 3: AES-256, latency 14
    start(1, P_A, K_C);
    wait_out(1, ct, lat);
    check("v3_ct", ct, C_C);
    check("v3_lat", 128'(lat), 128'd14);
    pop(1);
    check("v3_idle", {127'b0, ir2}, 128'd1);

    // 4: backpressure for 20 cycles
    start(0, P_A, {K_A, 128'h0});
    wait_out(0, ct, lat);
    chg = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (q1 !== C_A || ov1 !== 1'b1 || ir1 !== 1'b0) chg++;
    end
    check("bp_stable_cycles", 128'(chg), 128'd0);
    check("bp_dataout", q1, C_A);
    check("bp_out_valid", {127'b0, ov1}, 128'd1);
    check("bp_in_ready", {127'b0, ir1}, 128'd0);
    pop(0);
    check("bp_released_ready", {127'b0, ir1}, 128'd1);
    check("bp_released_valid", {127'b0, ov1}, 128'd0);

    // 5: in_valid and new data while busy are ignored
    start(0, P_B, {K_B, 128'h0});
    step(3);
    iv1 = 1'b1;
    d1  = 128'h0;
    k1  = {128{1'b1}};
    step(2);
    iv1 = 1'b0;
    wait_out(0, ct, lat);
    check("busy_ign_ct", ct, C_B);
    pop(0);
    outs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ov1) outs++;
    end
    check("busy_ign_outputs", 128'(outs), 128'd0);

    // 6: async reset between edges during round 5
    start(0, P_A, {K_A, 128'h0});
    step(4);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {127'b0, ov1}, 128'd0);
    check("arst_in_ready", {127'b0, ir1}, 128'd1);
    check("arst_dataout", q1, 128'd0);
    check("arst_busy", {127'b0, bz1}, 128'd0);
    step(1);
    rst = 1'b0;
    step(1);
    start(0, P_B, {K_B, 128'h0});
    wait_out(0, ct, lat);
    check("arst_after_ct", ct, C_B);
    check("arst_after_lat", 128'(lat), 128'd10);
    pop(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
